// File: rtl/ram_arbiter.sv
// Two-requester round-robin sequencer in front of the 32x32 single-port ram.
// Each granted access walks IDLE -> ACCESS -> (WAIT) -> DONE with registered ram controls.
module ram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              ram_cen,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  state_t state;
  logic   gnt;
  logic   last;
  logic   pick1;

  // requester 1 wins when alone, or on a tie when 0 was served last
  assign pick1 = req1 & (~req0 | ~last);
  assign busy  = (state != IDLE);

  // arbitration and access sequencing, all outputs registered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last     <= 1'b1;
      ram_cen  <= 1'b0;
      ram_wen  <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            gnt      <= pick1;
            last     <= pick1;
            ram_cen  <= 1'b1;
            ram_wen  <= pick1 ? we1 : we0;
            ram_addr <= pick1 ? addr1 : addr0;
            ram_din  <= pick1 ? wdata1 : wdata0;
            state    <= ACCESS;
          end else begin
            ram_cen  <= 1'b0;
          end
        end
        ACCESS: begin
          ram_cen <= 1'b0;
          ram_wen <= 1'b0;
          if (ram_wen) begin
            ack0  <= ~gnt;
            ack1  <= gnt;
            state <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (gnt) begin
            rdata1 <= ram_dout;
            ack1   <= 1'b1;
          end else begin
            rdata0 <= ram_dout;
            ack0   <= 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port ram model.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, req1, we0, we1;
  logic [4:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1, busy;
  logic [31:0] rdata0, rdata1;
  logic        ram_cen, ram_wen;
  logic [4:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic [31:0] mem [32];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .ram_cen(ram_cen), .ram_wen(ram_wen),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // single-port ram: write or registered read when enabled
  always @(posedge clk) begin
    if (ram_cen) begin
      if (ram_wen) mem[ram_addr] <= ram_din;
      else ram_dout <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // one access from one port; checks latency and read data
  task automatic access(input int p, input logic w, input logic [4:0] a,
                        input logic [31:0] d, input int lat, input string tag);
    int n;
    logic got;
    if (p == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    n = 0;
    got = 0;
    while (!got && n < 10) begin
      tick();
      n++;
      got = (p == 0) ? ack0 : ack1;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_both"}, {31'b0, ack0 & ack1}, 0);
    if (!w) chk({tag, "_rd"}, (p == 0) ? rdata0 : rdata1, d);
    if (p == 0) req0 = 0; else req1 = 0;
    tick();
  endtask

  initial begin
    int last_t, cnt0, cnt1, nxt, c;
    reset_n = 0;
    req0 = 1; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

    // 1 reset
    tick(); tick();
    chk("rst_cen", {31'b0, ram_cen}, 0);
    chk("rst_ack0", {31'b0, ack0}, 0);
    chk("rst_ack1", {31'b0, ack1}, 0);
    chk("rst_rd0", rdata0, 0);
    chk("rst_rd1", rdata1, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    req0 = 0;
    reset_n = 1;
    tick();

    // 2 write from port 0
    req0 = 1; we0 = 1; addr0 = 1; wdata0 = 32'h1111_1111;
    tick();
    chk("w0_cen", {31'b0, ram_cen}, 1);
    chk("w0_wen", {31'b0, ram_wen}, 1);
    chk("w0_addr", {27'b0, ram_addr}, 1);
    chk("w0_din", ram_din, 32'h1111_1111);
    chk("w0_busy", {31'b0, busy}, 1);
    chk("w0_noack", {31'b0, ack0}, 0);
    tick();
    chk("w0_ack", {31'b0, ack0}, 1);
    chk("w0_ack1", {31'b0, ack1}, 0);
    chk("w0_cenoff", {31'b0, ram_cen}, 0);
    chk("w0_wenoff", {31'b0, ram_wen}, 0);
    req0 = 0;
    tick();
    chk("w0_ackdrop", {31'b0, ack0}, 0);
    chk("w0_idle", {31'b0, busy}, 0);

    // 3 read back on port 1
    access(1, 0, 1, 32'h1111_1111, 3, "rb1");
    chk("rb1_rd0", rdata0, 0);

    // 4 tie from reset
    reset_n = 0; tick(); reset_n = 1;
    req0 = 1; we0 = 1; addr0 = 2; wdata0 = 32'h2222_2222;
    req1 = 1; we1 = 1; addr1 = 3; wdata1 = 32'h3333_3333;
    tick();
    chk("tie_first", {27'b0, ram_addr}, 2);
    tick();
    chk("tie_ack0", {31'b0, ack0}, 1);
    chk("tie_ack1n", {31'b0, ack1}, 0);
    req0 = 0;
    tick();
    tick();
    chk("tie_second", {27'b0, ram_addr}, 3);
    tick();
    chk("tie_ack1", {31'b0, ack1}, 1);
    chk("tie_ack0n", {31'b0, ack0}, 0);
    req1 = 0;
    tick();
    access(0, 0, 2, 32'h2222_2222, 3, "rd2");
    access(1, 0, 3, 32'h3333_3333, 3, "rd3");
    req0 = 1; we0 = 0; addr0 = 2;
    req1 = 1; we1 = 0; addr1 = 3;
    tick();
    chk("tie2_first", {27'b0, ram_addr}, 2);
    tick(); tick();
    chk("tie2_ack0", {31'b0, ack0}, 1);
    chk("tie2_rd0", rdata0, 32'h2222_2222);
    req0 = 0;
    tick(); tick();
    chk("tie2_second", {27'b0, ram_addr}, 3);
    tick(); tick();
    chk("tie2_ack1", {31'b0, ack1}, 1);
    chk("tie2_rd1", rdata1, 32'h3333_3333);
    chk("tie2_rd0hold", rdata0, 32'h2222_2222);
    req1 = 0;
    tick();

    // 5 reset during WAIT of a read
    req1 = 1; we1 = 0; addr1 = 3;
    tick();
    tick();
    chk("mid_wait", {31'b0, busy}, 1);
    reset_n = 0;
    tick();
    chk("mid_ack1", {31'b0, ack1}, 0);
    chk("mid_cen", {31'b0, ram_cen}, 0);
    chk("mid_idle", {31'b0, busy}, 0);
    req1 = 0;
    reset_n = 1;
    tick();
    access(1, 0, 3, 32'h3333_3333, 3, "retry");

    // 6 continuous contention, 8 reads per port
    req0 = 1; we0 = 0; addr0 = 2;
    req1 = 1; we1 = 0; addr1 = 3;
    cnt0 = 0; cnt1 = 0; nxt = 0; last_t = 0; c = 0;
    while ((cnt0 < 8 || cnt1 < 8) && c < 80) begin
      tick();
      c++;
      chk("cont_dual", {31'b0, ack0 & ack1}, 0);
      if (ack0 || ack1) begin
        chk("cont_order", {31'b0, ack1}, nxt[31:0]);
        chk("cont_gap", c - last_t, (last_t == 0) ? 3 : 4);
        if (ack0) begin
          chk("cont_rd0", rdata0, 32'h2222_2222);
          cnt0++;
          if (cnt0 == 8) req0 = 0;
        end else begin
          chk("cont_rd1", rdata1, 32'h3333_3333);
          cnt1++;
          if (cnt1 == 8) req1 = 0;
        end
        nxt = 1 - nxt;
        last_t = c;
      end
    end
    chk("cont_cnt0", cnt0, 8);
    chk("cont_cnt1", cnt1, 8);
    tick();
    chk("cont_idle", {31'b0, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
